// File: rtl/stream_box_downsampler_pkg.sv
// stream_box_downsampler: shared types, sizing helpers
// and default-geometry derived constants.
package sbd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_SOF,
    CAPTURE,
    DRAIN,
    DONE
  } sbd_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  function automatic int frame_n(input int out_size, input int pad);
    return out_size + 2 * pad;
  endfunction

  function automatic int crop_edge(input int out_size, input int scale);
    return out_size * scale;
  endfunction

  function automatic int shift_of(input int scale);
    return 2 * clog2(scale);
  endfunction

  function automatic int acc_w(input int pix_w, input int scale);
    return pix_w + shift_of(scale);
  endfunction

  localparam int N         = frame_n(28, 2);
  localparam int CROP_EDGE = crop_edge(28, 16);
  localparam int SHIFT     = shift_of(16);
  localparam int ACC_W     = acc_w(12, 16);

endpackage

// File: rtl/stream_box_downsampler_if.sv
// stream_box_downsampler: image RAM write port bundle.
// The downsampler is master, the RAM is slave.
interface stream_box_downsampler_if #(
  parameter int AW    = 10,
  parameter int OUT_W = 8
) ();
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [OUT_W-1:0] mem_wdata;

  modport master (
    output mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/stream_box_downsampler_tile_acc.sv
// sbd_tile_acc: one accumulator per tile column;
// accumulate, or read top bits and clear one entry.
module sbd_tile_acc #(
  parameter int OUT_SIZE = 28,
  parameter int PIX_W    = 12,
  parameter int ACC_W    = 20,
  parameter int OUT_W    = 8,
  parameter int CW       = 5
) (
  input  logic             D5M_PIXCLK,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             acc_en,
  input  logic [CW-1:0]    acc_col,
  input  logic [PIX_W-1:0] acc_data,
  input  logic             drn_en,
  input  logic [CW-1:0]    drn_idx,
  output logic [OUT_W-1:0] drn_top
);

  logic [ACC_W-1:0] acc [OUT_SIZE];

  // average = sum >> SHIFT; its top OUT_W bits are
  // simply the top OUT_W bits of the sum
  assign drn_top = acc[drn_idx][ACC_W-1 -: OUT_W];

  // single port: clear-all, drain-clear or accumulate
  always_ff @(posedge D5M_PIXCLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_SIZE; i++) acc[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < OUT_SIZE; i++) acc[i] <= '0;
    end else if (drn_en) begin
      acc[drn_idx] <= '0;
    end else if (acc_en) begin
      acc[acc_col] <= acc[acc_col] + ACC_W'(acc_data);
    end
  end

endmodule

// File: rtl/stream_box_downsampler.sv
// stream_box_downsampler: crop, box-average and pad one
// camera frame straight into an image RAM write port.
module stream_box_downsampler
  import sbd_pkg::*;
#(
  parameter int IN_W     = 640,
  parameter int CROP_X0  = 96,
  parameter int CROP_Y0  = 16,
  parameter int SCALE    = 16,
  parameter int OUT_SIZE = 28,
  parameter int PAD      = 2,
  parameter int PIX_W    = 12,
  parameter int OUT_W    = 8,
  parameter int PAD_VAL  = 0,
  parameter int INVERT   = 1,
  parameter int AW       = 10
) (
  input  logic             D5M_PIXCLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_dval,
  input  logic [15:0]      pix_x,
  input  logic [15:0]      pix_y,
  input  logic             frame_val,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  stream_box_downsampler_if.master mem
);

  localparam int NPIX = frame_n(OUT_SIZE, PAD);
  localparam int NN   = NPIX * NPIX;
  localparam int EDGE = crop_edge(OUT_SIZE, SCALE);
  localparam int LS   = clog2(SCALE);
  localparam int AWID = acc_w(PIX_W, SCALE);
  localparam int CW   = (clog2(OUT_SIZE) < 1) ? 1 : clog2(OUT_SIZE);

  localparam logic [15:0] X0   = 16'(CROP_X0);
  localparam logic [15:0] X1   = 16'(CROP_X0 + EDGE);
  localparam logic [15:0] XW   = 16'(IN_W);
  localparam logic [15:0] Y0   = 16'(CROP_Y0);
  localparam logic [15:0] Y1   = 16'(CROP_Y0 + EDGE);
  localparam logic [15:0] XL   = 16'(EDGE - 1);
  localparam logic [15:0] MASK = 16'(SCALE - 1);
  localparam logic [OUT_W-1:0] PADV = OUT_W'(PAD_VAL);

  sbd_state_e       state, state_n;
  logic [AW:0]      cnt, cnt_n;
  logic [CW-1:0]    by, by_n;
  logic             trunc, trunc_n;
  logic             fv_q, ovr_q, ovr_n;
  logic             done_q, busy_q;
  logic             we_q, we_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [OUT_W-1:0] wdata_q, wdata_d;
  logic             clr, acc_en, drn_en;
  logic [15:0]      dx, dy;
  logic             in_crop, tile_end;
  logic             fv_rise, fv_fall;
  logic [OUT_W-1:0] drn_top, pix_out;
  logic [AW-1:0]    drn_addr;

  assign dx = pix_x - X0;
  assign dy = pix_y - Y0;
  assign in_crop = pix_dval
                 && pix_x >= X0 && pix_x < X1
                 && pix_x < XW
                 && pix_y >= Y0 && pix_y < Y1;
  assign tile_end = ((dy & MASK) == MASK) && (dx == XL);
  assign fv_rise  = frame_val && !fv_q;
  assign fv_fall  = !frame_val && fv_q;
  assign pix_out  = (INVERT != 0) ? ~drn_top : drn_top;
  assign drn_addr = AW'((PAD + int'(by)) * NPIX
                        + PAD + int'(cnt[CW-1:0]));

  sbd_tile_acc #(
    .OUT_SIZE (OUT_SIZE),
    .PIX_W    (PIX_W),
    .ACC_W    (AWID),
    .OUT_W    (OUT_W),
    .CW       (CW)
  ) u_acc (
    .D5M_PIXCLK (D5M_PIXCLK),
    .rst_n      (rst_n),
    .clr        (clr),
    .acc_en     (acc_en),
    .acc_col    (dx[LS +: CW]),
    .acc_data   (pix_data),
    .drn_en     (drn_en),
    .drn_idx    (cnt[CW-1:0]),
    .drn_top    (drn_top)
  );

  // next state, counters and the write to register
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    by_n    = by;
    trunc_n = trunc;
    ovr_n   = ovr_q;
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    clr     = 1'b0;
    acc_en  = 1'b0;
    drn_en  = 1'b0;
    if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      by_n    = '0;
      trunc_n = 1'b0;
      clr     = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          clr     = 1'b1;
          by_n    = '0;
          trunc_n = 1'b0;
          if (start) begin
            state_n = CLEAR;
            cnt_n   = (AW+1)'(1);
            ovr_n   = 1'b0;
            we_d    = 1'b1;
            wdata_d = PADV;
          end
        end
        CLEAR: begin
          if (cnt == (AW+1)'(NN)) begin
            state_n = WAIT_SOF;
            cnt_n   = '0;
          end else begin
            we_d    = 1'b1;
            waddr_d = cnt[AW-1:0];
            wdata_d = PADV;
            cnt_n   = cnt + 1'b1;
          end
        end
        WAIT_SOF: begin
          if (fv_rise) state_n = CAPTURE;
        end
        CAPTURE: begin
          if (fv_fall) begin
            state_n = DONE;
          end else if (in_crop) begin
            acc_en = 1'b1;
            if (tile_end) begin
              state_n = DRAIN;
              cnt_n   = '0;
            end
          end
        end
        DRAIN: begin
          drn_en  = 1'b1;
          we_d    = 1'b1;
          waddr_d = drn_addr;
          wdata_d = pix_out;
          if (in_crop) ovr_n = 1'b1;
          if (fv_fall) trunc_n = 1'b1;
          if (cnt[CW-1:0] == CW'(OUT_SIZE - 1)) begin
            cnt_n = '0;
            if (by == CW'(OUT_SIZE - 1) || trunc || fv_fall) begin
              state_n = DONE;
            end else begin
              by_n    = by + 1'b1;
              state_n = CAPTURE;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // state and registered outputs; busy drops as done pulses
  always_ff @(posedge D5M_PIXCLK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      by      <= '0;
      trunc   <= 1'b0;
      fv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      by      <= by_n;
      trunc   <= trunc_n;
      fv_q    <= frame_val;
      ovr_q   <= ovr_n;
      done_q  <= (state == DONE);
      busy_q  <= (state_n != IDLE);
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign overrun       = ovr_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_waddr = waddr_q;
  assign mem.mem_wdata = wdata_q;

endmodule
